// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
//
// Loadable down-counter driven by an external time-unit tick.
// The FSM has three states: IDLE, RUN and PAUSE.
// Commands are evaluated once per cycle in this priority order:
//     rst > load > pause > start > tick
// A tick that arrives together with load, pause or start is thrown away.
// When TickSync is 1, the cleaned tick is registered once before it is used.
// This adds one cycle of tick latency.
//
// Optional feature (compile-time macro COUNTDOWN_TIMER_AUTORELOAD_EN):
//     On expiry the block pulses done and reloads count from the last loaded
//     value. It stays in RUN. If that value is zero, it returns to IDLE.
//     When the macro is undefined, expiry always returns to IDLE. In that
//     build the reload register is not present.
//
// Parameters:
//     Width      count width in bits
//     TickSync   1: register tick before use, 0: use tick directly
//
// Ports:
//     clk         single clock, all state changes on its rising edge
//     rst         synchronous active-high reset
//     tick        one-cycle pulse per time unit
//     load        capture load_value into count (and into reload)
//     load_value  countdown start value
//     start       begin, or resume, the countdown
//     pause       suspend the countdown
//     count       remaining value (registered)
//     busy        high while in RUN or PAUSE (registered)
//     done        one-cycle expiry pulse (registered)
// -----------------------------------------------------------------------------
module countdown_timer #(
    parameter int Width    = 8,
    parameter int TickSync = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             load,
    input  logic [Width-1:0] load_value,
    input  logic             start,
    input  logic             pause,
    output logic [Width-1:0] count,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [Width-1:0] CountZero = {Width{1'b0}};
    localparam logic [Width-1:0] CountOne  = Width'(1);

    state_t state;
    logic   cmd;
    logic   tick_clean;
    logic   tick_eff;

`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
    logic [Width-1:0] reload;
`endif

    // Any command consumes the cycle, so a tick that arrives with one is lost.
    assign cmd        = load | pause | start;
    assign tick_clean = tick & ~cmd;

    generate
        if (TickSync != 0) begin : g_tick_sync
            logic tick_q;

            // Hold the cleaned tick for one cycle before the FSM uses it.
            always_ff @(posedge clk) begin
                if (rst) begin
                    tick_q <= 1'b0;
                end else begin
                    tick_q <= tick_clean;
                end
            end

            // A command in the cycle of use still takes priority over the delayed tick.
            assign tick_eff = tick_q & ~cmd;
        end else begin : g_tick_direct
            assign tick_eff = tick_clean;
        end
    endgenerate

    // Main FSM: state, count, busy and done are all updated in this block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= CountZero;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
            reload <= CountZero;
`endif
        end else begin
            done <= 1'b0;
            if (load) begin
                count <= load_value;
                state <= IDLE;
                busy  <= 1'b0;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
                reload <= load_value;
`endif
            end else if (pause) begin
                if (state == RUN) begin
                    state <= PAUSE;
                    busy  <= 1'b1;
                end
            end else if (start) begin
                case (state)
                    IDLE: begin
                        if (count != CountZero) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end else begin
                            // Starting with nothing left expires at once.
                            done <= 1'b1;
                        end
                    end
                    PAUSE: begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                    default: begin
                        // Start while already running has no effect.
                    end
                endcase
            end else if (tick_eff && (state == RUN)) begin
                if (count == CountOne) begin
                    done <= 1'b1;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
                    if (reload != CountZero) begin
                        count <= reload;
                    end else begin
                        count <= CountZero;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
`else
                    count <= CountZero;
                    state <= IDLE;
                    busy  <= 1'b0;
`endif
                end else if (count != CountZero) begin
                    count <= count - CountOne;
                end
            end
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

    localparam int W    = 8;
    localparam int MAXV = (1 << W) - 1;

    logic         clk;
    logic         rst;
    logic         tick;
    logic         load;
    logic [W-1:0] load_value;
    logic         start;
    logic         pause;
    logic [W-1:0] count;
    logic         busy;
    logic         done;

    countdown_timer #(.Width(W), .TickSync(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .load       (load),
        .load_value (load_value),
        .start      (start),
        .pause      (pause),
        .count      (count),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] count;
        logic         busy;
        logic         done;
    } exp_t;

    exp_t exp_q[$];

    int total     = 0;
    int bad       = 0;
    int done_seen = 0;
    int cyc_no    = 0;

    // Reference model. mode: 0 = stopped, 1 = counting, 2 = suspended.
    // pend holds a tick that is on its way through the one-cycle sync delay.
    int mode      = 0;
    int m_count   = 0;
    int m_reload  = 0;
    bit m_done    = 0;
    bit pend      = 0;

    task automatic model_step(input bit r, input bit t, input bit l, input int v,
                              input bit s, input bit p);
        bit any_cmd;
        bit use_tick;
        if (r) begin
            mode = 0; m_count = 0; m_reload = 0; m_done = 0; pend = 0;
            return;
        end
        any_cmd  = l | s | p;
        use_tick = pend && !any_cmd;
        pend     = t && !any_cmd;
        m_done   = 0;
        if (l) begin
            m_count = v; m_reload = v; mode = 0;
        end else if (p) begin
            if (mode == 1) mode = 2;
        end else if (s) begin
            if (mode == 0) begin
                if (m_count > 0) mode = 1;
                else m_done = 1;
            end else if (mode == 2) begin
                mode = 1;
            end
        end else if (use_tick && mode == 1) begin
            m_count = m_count - 1;
            if (m_count == 0) begin
                m_done = 1;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
                if (m_reload > 0) m_count = m_reload;
                else mode = 0;
`else
                mode = 0;
`endif
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model, and queue the expected outputs.
    task automatic cyc(input bit r, input bit t, input bit l, input int v,
                       input bit s, input bit p);
        exp_t e;
        @(negedge clk);
        #1;
        rst = r; tick = t; load = l; load_value = v[W-1:0]; start = s; pause = p;
        model_step(r, t, l, v, s, p);
        e.count = m_count[W-1:0];
        e.busy  = (mode != 0);
        e.done  = m_done;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic ticks(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            cyc(0, 1, 0, 0, 0, 0);
            idle(gap);
        end
    endtask

    // Monitor: compare the DUT outputs with the oldest queued expectation after each edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc_no++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (done === 1'b1) done_seen++;
                if (count !== e.count || busy !== e.busy || done !== e.done) begin
                    bad++;
                    $display("FAIL outputs cycle=%0d got count=%0d busy=%0b done=%0b want count=%0d busy=%0b done=%0b",
                             cyc_no, count, busy, done, e.count, e.busy, e.done);
                end
            end
        end
    end

    initial begin
        int d0;
        rst = 1'b1; tick = 1'b0; load = 1'b0; load_value = '0; start = 1'b0; pause = 1'b0;

        // Reset held for two cycles while the other inputs are random.
        for (int i = 0; i < 2; i++)
            cyc(1, 1'($urandom), 1'($urandom), int'($urandom_range(0, MAXV)),
                1'($urandom), 1'($urandom));
        idle(2);

        // Basic countdown from 3.
        cyc(0, 0, 1, 3, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        ticks(3, 4);
        idle(2);

        // Pause and resume: ticks during the pause must be ignored.
        cyc(0, 0, 1, 5, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        ticks(2, 4);
        cyc(0, 0, 0, 0, 0, 1);
        ticks(4, 4);
        cyc(0, 0, 0, 0, 1, 0);
        ticks(3, 4);
        idle(2);

        // Collisions: a tick together with pause, then a tick together with load.
        cyc(0, 0, 1, 9, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        ticks(1, 4);
        cyc(0, 1, 0, 0, 0, 1);
        idle(3);
        cyc(0, 0, 0, 0, 1, 0);
        idle(1);
        cyc(0, 1, 1, 7, 0, 0);
        idle(4);

        // Zero load: start must give an immediate done with busy left low.
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        idle(3);

        // Full-scale countdown must give exactly one done.
        cyc(0, 0, 1, MAXV, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        idle(2);
        d0 = done_seen;
        ticks(MAXV, 1);
        idle(3);
        total++;
        if (done_seen - d0 != 1) begin
            bad++;
            $display("FAIL full_scale_done got=%0d want=1", done_seen - d0);
        end

        // Load 2, start, then 6 ticks (this exercises autoreload when it is built in).
        cyc(0, 0, 1, 2, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        d0 = done_seen;
        ticks(6, 2);
        idle(3);
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
        total++;
        if (done_seen - d0 != 3) begin
            bad++;
            $display("FAIL autoreload_dones got=%0d want=3", done_seen - d0);
        end
`endif

        // Randomized traffic, biased toward small values so that expiries happen often.
        for (int i = 0; i < 3000; i++) begin
            int v;
            case ($urandom_range(0, 3))
                0: v = 0;
                1: v = 1;
                2: v = MAXV;
                default: v = int'($urandom_range(2, 12));
            endcase
            cyc(($urandom % 300) == 0, ($urandom % 3) == 0, ($urandom % 40) == 0, v,
                ($urandom % 10) == 0, ($urandom % 20) == 0);
        end
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
